fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer that owns the program counter and drives the instruction bus.
//   It runs a single-outstanding req/gnt/rvalid handshake and presents one instruction at a time to decode.
//   It applies trap and jump redirects, flushing and discarding any in-flight fetch.
//   It sits between the core pipeline and the instruction memory port.
// PARAMETERS
//   ADDR_W      32            PC / bus address width
//   DATA_W      32            instruction width
//   RESET_ADDR  {ADDR_W{1'b0}} PC value at and after reset
//   PC_STEP     1             PC increment per fetch (word addressing)
//   NOP_INST    32'h00000013  value of inst_o when invalid
// PORTS
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       synchronous, active-high reset
//   trap_flag_i    in   1       trap redirect request (highest priority)
//   trap_addr_i    in   ADDR_W  trap target
//   jump_flag_i    in   1       branch/jump redirect request
//   jump_addr_i    in   ADDR_W  jump target
//   hold_i         in   1       decode stall; output slot not consumed this cycle
//   ibus_req_o     out  1       fetch request
//   ibus_addr_o    out  ADDR_W  fetch address, equal to the address of the request issued
//   ibus_gnt_i     in   1       request accepted this cycle
//   ibus_rvalid_i  in   1       read data valid (exactly one per grant)
//   ibus_rdata_i   in   DATA_W  read data
//   pc_o           out  ADDR_W  address of the next instruction to request
//   inst_o         out  DATA_W  instruction to decode
//   inst_addr_o    out  ADDR_W  address of inst_o
//   inst_valid_o   out  1       inst_o valid; consumed when inst_valid_o && !hold_i
// BEHAVIOUR
//   Reset (rst_i=1) values:
//   - state=IDLE, pc_o=RESET_ADDR, ibus_req_o=0, ibus_addr_o=RESET_ADDR
//   - inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0, skid buffer empty
//   - Reset overrides everything, including mid-transaction; the bus is reset on the same rst_i.
//   States:
//   - IDLE  -> FETCH on the first cycle with rst_i=0.
//   - FETCH: ibus_req_o=1 iff the skid buffer is empty; ibus_addr_o=pc_o, held stable until gnt.
//     On gnt: req_addr<=pc_o, pc_o<=pc_o+PC_STEP (mod 2^ADDR_W), go WAIT.
//   - WAIT: ibus_req_o=0. On rvalid:
//     - if inst_valid_o && hold_i: load skid {rdata, req_addr}, go HOLD;
//     - else: inst_o<=rdata, inst_addr_o<=req_addr, inst_valid_o<=1 next cycle, go FETCH.
//     Fetch-to-inst_valid_o latency is gnt + rvalid + 1 cycle.
//   - HOLD: ibus_req_o=0. When hold_i=0, the skid moves to the output regs next cycle, skid empties, go FETCH.
//   - DROP: discard the next rvalid, then go FETCH.
//   Consume rule: inst_valid_o && !hold_i with no new data loaded -> inst_valid_o<=0.
//   hold_i=1 freezes inst_o, inst_addr_o and inst_valid_o.
//   Redirect (trap_flag_i wins over jump_flag_i; both are ignored during reset):
//   - pc_o<=target; inst_valid_o<=0 (flush overrides hold_i); skid cleared.
//   - FETCH without gnt: request withdrawn and re-issued at the target next cycle.
//   - FETCH with gnt in the same cycle: go DROP.
//   - WAIT without rvalid: go DROP.
//   - WAIT with rvalid, or DROP with rvalid: data discarded, go FETCH.
//   - HOLD: go FETCH.
//   - DROP without rvalid: stay DROP with the new target.
//   - A gnt taken on a redirect cycle does not increment pc_o.
//   - No instruction from a pre-redirect address is ever delivered with inst_valid_o=1.
//   pc_o wraps from 2^ADDR_W-PC_STEP to 0 with no flag.
// TESTING
//   1. Reset, zero-wait memory (gnt same cycle as req, rvalid next cycle): addresses 0,1,2,3 issued;
//      inst_valid_o first high 3 cycles after reset release; inst_addr_o=0,1,2,3.
//   2. hold_i=1 for 5 cycles while valid: inst_o stable; 2nd response parks in skid, no new req;
//      release -> the next instruction appears 1 cycle later, no loss or duplication.
//   3. jump_flag_i=1, jump_addr_i=0x40 in WAIT: in-flight rdata dropped; next ibus_addr_o=0x40;
//      first valid inst_addr_o=0x40.
//   4. trap_flag_i and jump_flag_i together (0x100 vs 0x40): pc_o=0x100, jump ignored.
//   5. Redirect on the same cycle as rvalid, and redirect while in DROP: no stale instruction valid;
//      fetch resumes at the last target.
//   6. pc_o=2^ADDR_W-1 with PC_STEP=1: next pc_o=0. rst_i mid-WAIT: all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter and runs a single-outstanding req/gnt/rvalid fetch
// on the instruction bus. Presents one instruction at a time to decode, with a
// one-entry skid buffer for a response that lands while decode is stalled.
// Trap/jump redirects flush the output and skid and discard any in-flight fetch.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   trap_flag_i/trap_addr_i       trap redirect (wins over jump)
//   jump_flag_i/jump_addr_i       branch/jump redirect
//   hold_i                        decode stall
//   ibus_req_o/ibus_addr_o        fetch request and its address
//   ibus_gnt_i                    request accepted
//   ibus_rvalid_i/ibus_rdata_i    read response
//   pc_o                          address of next instruction to request
//   inst_o/inst_addr_o            instruction to decode and its address
//   inst_valid_o                  inst_o valid; consumed when !hold_i
module fetch_ctrl #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(1),
  parameter logic [DATA_W-1:0] NOP_INST   = DATA_W'(32'h0000_0013)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_flag_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DROP  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              granted;

  // Request is a pure decode of registered state; address is the PC itself,
  // so both stay stable until the grant.
  assign ibus_req_o    = (state_q == ST_FETCH) && !skid_valid_q;
  assign ibus_addr_o   = pc_q;
  assign granted       = ibus_req_o && ibus_gnt_i;
  assign redirect      = trap_flag_i || jump_flag_i;
  assign redirect_addr = trap_flag_i ? trap_addr_i : jump_addr_i;

  assign pc_o          = pc_q;
  assign inst_o        = inst_q;
  assign inst_addr_o   = inst_addr_q;
  assign inst_valid_o  = inst_valid_q;

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_addr_d  = skid_addr_q;

    // Output slot consumed; any load below overrides this.
    if (inst_valid_q && !hold_i) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (granted) begin
          req_addr_d = pc_q;
          if (redirect) begin
            state_d = ST_DROP;
          end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (ibus_rvalid_i) begin
          if (redirect) begin
            state_d = ST_FETCH;
          end else if (inst_valid_q && hold_i) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ibus_rdata_i;
            skid_addr_d  = req_addr_q;
            state_d      = ST_HOLD;
          end else begin
            inst_d       = ibus_rdata_i;
            inst_addr_d  = req_addr_q;
            inst_valid_d = 1'b1;
            state_d      = ST_FETCH;
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_FETCH;
        end else if (!hold_i) begin
          inst_d       = skid_data_q;
          inst_addr_d  = skid_addr_q;
          inst_valid_d = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end

      ST_DROP: begin
        if (ibus_rvalid_i) begin
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Flush wins over hold and over any load above.
    if (redirect) begin
      pc_d         = redirect_addr;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      skid_valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_ADDR;
      req_addr_q   <= RESET_ADDR;
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_INST;
      skid_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_addr_q  <= skid_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: bench for fetch_ctrl with a behavioural memory responder and
// an address-stream scoreboard (delivered instructions must follow the last
// redirect target sequentially).
module tb_fetch_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          trap, jump, hold;
  logic [AW-1:0] trap_addr, jump_addr;
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] pc;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_addr;
  logic          inst_valid;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pops = 0;

  // responder controls
  int unsigned grant_pct = 100;
  bit          rand_lat  = 1'b0;
  int unsigned lat_fix   = 0;

  logic [AW-1:0] exp_q[$];

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .trap_flag_i  (trap),
    .trap_addr_i  (trap_addr),
    .jump_flag_i  (jump),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .ibus_req_o   (req),
    .ibus_addr_o  (addr),
    .ibus_gnt_i   (gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i (rdata),
    .pc_o         (pc),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_chk);
    $fatal(1);
  end

  // Memory contents: odd multiplier keeps every address distinct.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic refill();
    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd1);
  endtask

  task automatic restart_stream(input logic [AW-1:0] a);
    exp_q.delete();
    exp_q.push_back(a);
    refill();
  endtask

  // Memory responder: random or fixed latency, one outstanding, reset with rst.
  initial begin
    logic          r;
    logic          pend;
    int unsigned   lat;
    logic [AW-1:0] paddr;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    pend = 1'b0; lat = 0; paddr = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      gnt = 1'b0;
      rvalid = 1'b0;
      if (r) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (lat == 0) begin
            rvalid = 1'b1;
            rdata  = memf(paddr);
            pend   = 1'b0;
          end else begin
            lat--;
          end
        end
        if (req && !pend && !rvalid && ($urandom_range(99, 0) < grant_pct)) begin
          gnt   = 1'b1;
          paddr = addr;
          pend  = 1'b1;
          lat   = rand_lat ? $urandom_range(3, 0) : lat_fix;
        end
      end
    end
  end

  // Monitor / scoreboard: consumption is checked before a same-cycle redirect.
  initial begin
    logic [AW-1:0] a;
    restart_stream('0);
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        restart_stream('0);
      end else begin
        if (inst_valid && !hold) begin
          a = exp_q.pop_front();
          refill();
          chk("deliver_addr", inst_addr, a);
          chk("deliver_data", inst, memf(a));
          n_pops++;
        end
        if (!inst_valid) chk("nop_when_invalid", inst, NOP);
        if (trap) restart_stream(trap_addr);
        else if (jump) restart_stream(jump_addr);
      end
    end
  end

  task automatic step1(); @(posedge clk); #1; endtask
  task automatic step2(); @(posedge clk); #2; endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!inst_valid && k < 100) begin step1(); k++; end
    chk(name, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!req && k < 100) begin step1(); k++; end
    chk(name, 32'(req), 32'd1);
  endtask

  task automatic wait_grant(input string name);
    int k = 0;
    do begin step2(); k++; end while (!(req && gnt) && k < 100);
    chk(name, 32'(req && gnt), 32'd1);
  endtask

  task automatic wait_rvalid(input string name);
    int k = 0;
    do begin step2(); k++; end while (!rvalid && k < 100);
    chk(name, 32'(rvalid), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_inst_addr"}, inst_addr, 32'h0);
  endtask

  initial begin
    int base;
    rst = 1'b1; trap = 1'b0; jump = 1'b0; hold = 1'b0;
    trap_addr = '0; jump_addr = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Zero-wait memory: addresses 0..3, first valid 3 cycles after release
    for (int i = 1; i <= 9; i++) begin
      step1();
      if (i <= 2) chk("t1_valid_low", 32'(inst_valid), 32'd0);
      if (i >= 3 && (i % 2) == 1) begin
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_inst_addr", inst_addr, 32'((i - 3) / 2));
      end
      if (i <= 7 && (i % 2) == 1) begin
        chk("t1_req", 32'(req), 32'd1);
        chk("t1_req_addr", addr, 32'((i - 1) / 2));
      end
    end

    // Hold for 5 cycles: output frozen, response parks in skid, no new request
    hold = 1'b1;
    repeat (5) begin
      step1();
      chk("t2_valid", 32'(inst_valid), 32'd1);
      chk("t2_inst_addr", inst_addr, 32'h3);
      chk("t2_inst", inst, memf(32'h3));
      chk("t2_no_req", 32'(req), 32'd0);
    end
    hold = 1'b0;
    lat_fix = 2;
    step1();
    chk("t2_release_valid", 32'(inst_valid), 32'd1);
    chk("t2_release_addr", inst_addr, 32'h4);

    // Jump while WAIT: in-flight data dropped, refetch at 0x40
    step1();
    jump = 1'b1; jump_addr = 32'h40;
    step1();
    jump = 1'b0;
    chk("t3_pc", pc, 32'h40);
    chk("t3_valid_flushed", 32'(inst_valid), 32'd0);
    wait_req("t3_req_timeout");
    chk("t3_req_addr", addr, 32'h40);
    wait_valid("t3_valid_timeout");
    chk("t3_inst_addr", inst_addr, 32'h40);

    // Trap and jump together: trap wins
    step1();
    trap = 1'b1; trap_addr = 32'h100; jump = 1'b1; jump_addr = 32'h40;
    step1();
    trap = 1'b0; jump = 1'b0;
    chk("t4_pc", pc, 32'h100);
    chk("t4_valid_flushed", 32'(inst_valid), 32'd0);
    wait_valid("t4_valid_timeout");
    chk("t4_inst_addr", inst_addr, 32'h100);

    // Redirect in the same cycle as rvalid
    step2();
    lat_fix = 1;
    wait_rvalid("t5a_rvalid_timeout");
    jump = 1'b1; jump_addr = 32'h80;
    step1();
    jump = 1'b0;
    chk("t5a_valid_flushed", 32'(inst_valid), 32'd0);
    chk("t5a_pc", pc, 32'h80);
    wait_valid("t5a_valid_timeout");
    chk("t5a_inst_addr", inst_addr, 32'h80);

    // Redirect in WAIT, then again while in DROP: last target wins
    step2();
    lat_fix = 3;
    wait_grant("t5b_grant_timeout");
    step2();
    chk("t5b_wait_no_rvalid", 32'(rvalid), 32'd0);
    jump = 1'b1; jump_addr = 32'h180;
    step2();
    chk("t5b_drop_no_rvalid", 32'(rvalid), 32'd0);
    jump_addr = 32'h200;
    step1();
    jump = 1'b0;
    chk("t5b_pc", pc, 32'h200);
    chk("t5b_valid_flushed", 32'(inst_valid), 32'd0);
    wait_valid("t5b_valid_timeout");
    chk("t5b_inst_addr", inst_addr, 32'h200);

    // PC wrap from all-ones to zero
    step2();
    lat_fix = 0;
    step1();
    jump = 1'b1; jump_addr = 32'hFFFF_FFFF;
    step1();
    jump = 1'b0;
    chk("t6_pc_top", pc, 32'hFFFF_FFFF);
    wait_grant("t6_grant_timeout");
    chk("t6_grant_addr", addr, 32'hFFFF_FFFF);
    step1();
    chk("t6_pc_wrap", pc, 32'h0);
    wait_valid("t6_valid_timeout");
    chk("t6_inst_addr", inst_addr, 32'hFFFF_FFFF);

    // Reset in the middle of WAIT
    step2();
    lat_fix = 3;
    wait_grant("t6r_grant_timeout");
    step1();
    rst = 1'b1;
    step1();
    chk_reset_vals("t6r");
    rst = 1'b0;

    // Random traffic against the scoreboard
    step2();
    grant_pct = 60;
    rand_lat  = 1'b1;
    base = n_pops;
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      step1();
      hold = ($urandom_range(99, 0) < 30);
      r = $urandom_range(99, 0);
      trap = (r < 3);
      jump = (r >= 2 && r < 8);
      trap_addr = $urandom;
      jump_addr = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(1000, 0));
    end
    trap = 1'b0; jump = 1'b0; hold = 1'b0;
    repeat (30) step1();
    chk("random_progress", 32'(n_pops - base > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
